// File: rtl/tx_cp_insert_if.sv
// Sample-stream bundle for the CP insertion block: IFFT-side input, source
// flow control/error pulses, and the DAC-side output with frame position.
interface tx_cp_insert_if #(
    parameter int pDAT_W = 12
);
    logic                     isop;
    logic                     ival;
    logic signed [pDAT_W-1:0] idata_i;
    logic signed [pDAT_W-1:0] idata_q;
    logic                     ordy;
    logic                     oovf;
    logic                     oerr_sop;
    logic                     osop;
    logic                     osof;
    logic                     oval;
    logic signed [pDAT_W-1:0] odata_i;
    logic signed [pDAT_W-1:0] odata_q;
    logic [6:0]               count_frame;

    modport master (
        output isop, ival, idata_i, idata_q,
        input  ordy, oovf, oerr_sop, osop, osof, oval, odata_i, odata_q, count_frame
    );

    modport slave (
        input  isop, ival, idata_i, idata_q,
        output ordy, oovf, oerr_sop, osop, osof, oval, odata_i, odata_q, count_frame
    );
endinterface

// File: rtl/tx_cp_insert.sv
// Transmit cyclic-prefix insertion: ping-pong symbol buffer, each stored symbol
// is replayed as its last pCP_Len samples followed by the whole symbol.
module tx_cp_insert #(
    parameter int pDAT_W   = 12,
    parameter int pDAT_Num = 1024,
    parameter int pCP_Len  = 32,
    parameter int pSB_Num  = 50
) (
    input logic            clk,
    input logic            rst,
    tx_cp_insert_if.slave  bus
);
    localparam int AW = $clog2(pDAT_Num);
    localparam logic [AW-1:0] LAST_ADDR = AW'(pDAT_Num - 1);
    localparam logic [AW-1:0] CP_START  = AW'(pDAT_Num - pCP_Len);
    localparam logic [6:0]    LAST_SYM  = 7'(pSB_Num - 1);

    typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_t;

    logic [2*pDAT_W-1:0] mem [0:2*pDAT_Num-1];

    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wr_bank;
    logic          wr_active;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [AW-1:0] wr_waddr;
    logic          wr_start;
    logic          wr_restart;
    logic          wr_drop;
    logic          wr_done;

    rd_state_t     state;
    rd_state_t     state_next;
    logic          rd_bank;
    logic          rd_bank_next;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_addr_next;
    logic          rd_issue;
    logic          rd_sop;
    logic          rd_done;

    logic [2*pDAT_W-1:0] rd_data;
    logic                oval_q;
    logic                osop_q;
    logic                ordy_q;
    logic                oovf_q;
    logic                oerr_q;
    logic                seen_sop;
    logic [6:0]          count_q;

    // Write-side decode: isop always restarts at address 0, unless no bank is free.
    always_comb begin
        wr_en      = 1'b0;
        wr_waddr   = wr_addr;
        wr_start   = 1'b0;
        wr_restart = 1'b0;
        wr_drop    = 1'b0;
        wr_done    = 1'b0;
        if (bus.ival) begin
            if (bus.isop) begin
                if (wr_active) begin
                    wr_restart = 1'b1;
                    wr_en      = 1'b1;
                    wr_waddr   = '0;
                end else if (!full[wr_bank]) begin
                    wr_start = 1'b1;
                    wr_en    = 1'b1;
                    wr_waddr = '0;
                end else begin
                    wr_drop = 1'b1;
                end
            end else if (wr_active) begin
                wr_en   = 1'b1;
                wr_done = (wr_addr == LAST_ADDR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank   <= 1'b0;
            wr_active <= 1'b0;
            wr_addr   <= '0;
            oovf_q    <= 1'b0;
            oerr_q    <= 1'b0;
            ordy_q    <= 1'b0;
        end else begin
            if (wr_start || wr_restart) begin
                wr_active <= 1'b1;
                wr_addr   <= AW'(1);
            end else if (wr_en) begin
                if (wr_done) begin
                    wr_active <= 1'b0;
                    wr_bank   <= ~wr_bank;
                    wr_addr   <= '0;
                end else begin
                    wr_addr <= wr_addr + AW'(1);
                end
            end
            oovf_q <= wr_drop;
            oerr_q <= wr_restart;
            ordy_q <= ~full[wr_bank] & ~wr_active;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_waddr}] <= {bus.idata_i, bus.idata_q};
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

    // The writer only fills and the reader only drains the bank it owns, so a
    // simultaneous set and clear always land on different flags.
    always_comb begin
        full_next = full;
        if (wr_done) begin
            full_next[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_addr <= '0;
        end else begin
            full    <= full_next;
            state   <= state_next;
            rd_bank <= rd_bank_next;
            rd_addr <= rd_addr_next;
        end
    end

    always_comb begin
        state_next   = state;
        rd_bank_next = rd_bank;
        rd_addr_next = rd_addr;
        rd_issue     = 1'b0;
        rd_sop       = 1'b0;
        rd_done      = 1'b0;
        case (state)
            IDLE: begin
                if (full[rd_bank]) begin
                    state_next   = CP;
                    rd_addr_next = CP_START;
                end
            end
            CP: begin
                rd_issue = 1'b1;
                rd_sop   = (rd_addr == CP_START);
                if (rd_addr == LAST_ADDR) begin
                    state_next   = BODY;
                    rd_addr_next = '0;
                end else begin
                    rd_addr_next = rd_addr + AW'(1);
                end
            end
            BODY: begin
                rd_issue = 1'b1;
                if (rd_addr == LAST_ADDR) begin
                    rd_done      = 1'b1;
                    rd_bank_next = ~rd_bank;
                    if (full[~rd_bank]) begin
                        state_next   = CP;
                        rd_addr_next = CP_START;
                    end else begin
                        state_next   = IDLE;
                        rd_addr_next = '0;
                    end
                end else begin
                    rd_addr_next = rd_addr + AW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                rd_addr_next = '0;
            end
        endcase
    end

    // The very first symbol after reset keeps index 0; later ones advance it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oval_q   <= 1'b0;
            osop_q   <= 1'b0;
            seen_sop <= 1'b0;
            count_q  <= '0;
        end else begin
            oval_q <= rd_issue;
            osop_q <= rd_sop;
            if (rd_sop) begin
                seen_sop <= 1'b1;
                if (seen_sop) begin
                    count_q <= (count_q == LAST_SYM) ? 7'd0 : count_q + 7'd1;
                end
            end
        end
    end

    assign bus.ordy        = ordy_q;
    assign bus.oovf        = oovf_q;
    assign bus.oerr_sop    = oerr_q;
    assign bus.oval        = oval_q;
    assign bus.osop        = osop_q;
    assign bus.osof        = osop_q & (count_q == 7'd0);
    assign bus.count_frame = count_q;
    assign bus.odata_i     = oval_q ? rd_data[2*pDAT_W-1:pDAT_W] : '0;
    assign bus.odata_q     = oval_q ? rd_data[pDAT_W-1:0] : '0;
endmodule

// File: tb/tb_tx_cp_insert.sv
// Directed bench for tx_cp_insert: ramp symbols in, CP-prefixed stream logged at
// the falling edge and compared against hand-derived ramp positions.
module tb_tx_cp_insert;
    localparam int SYM_OUT = 1056;

    typedef struct {
        logic signed [11:0] i;
        logic signed [11:0] q;
        logic               sop;
        logic               sof;
        logic [6:0]         cf;
        int                 cyc;
    } out_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   ovf_cnt;
    int   err_cnt;
    int   zero_viol;
    int   last_edge;
    logic ordy_after_sop;
    out_t out_log[$];

    tx_cp_insert_if #(.pDAT_W(12)) bus ();

    tx_cp_insert #(
        .pDAT_W  (12),
        .pDAT_Num(1024),
        .pCP_Len (32),
        .pSB_Num (50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        out_t e;
        if (rst) begin
            if (bus.oval) begin
                e.i   = bus.odata_i;
                e.q   = bus.odata_q;
                e.sop = bus.osop;
                e.sof = bus.osof;
                e.cf  = bus.count_frame;
                e.cyc = cyc;
                out_log.push_back(e);
            end else if (bus.odata_i != 0 || bus.odata_q != 0 || bus.osop) begin
                zero_viol++;
            end
            if (bus.oovf) ovf_cnt++;
            if (bus.oerr_sop) err_cnt++;
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int tag, input int nsamp, input bit wait_rdy);
        int t;
        if (wait_rdy) begin
            t = 0;
            while (!bus.ordy && t < 4000) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (!bus.ordy) checkOutput("ordy wait", bus.ordy, 1);
        end
        for (int n = 0; n < nsamp; n++) begin
            bus.isop    = (n == 0);
            bus.ival    = 1'b1;
            bus.idata_i = 12'(n);
            bus.idata_q = 12'(tag - n);
            last_edge   = cyc + 1;
            @(posedge clk);
            #1;
            if (n == 0) ordy_after_sop = bus.ordy;
        end
        bus.isop    = 1'b0;
        bus.ival    = 1'b0;
        bus.idata_i = '0;
        bus.idata_q = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        bus.isop = 1'b0;
        bus.ival = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        out_log.delete();
        ovf_cnt = 0;
        err_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_entries(input int target, input int budget);
        int t;
        t = 0;
        while (out_log.size() < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (out_log.size() < target) checkOutput("output timeout", out_log.size(), target);
    endtask

    // One output symbol: 32 CP samples (ramp 992..1023) then ramp 0..1023.
    task automatic check_symbol(input int base, input int tag, input int exp_cf,
                                input bit exp_sof, input string name);
        int errs;
        int n;
        if (out_log.size() < base + SYM_OUT) begin
            checkOutput({name, " length"}, out_log.size(), base + SYM_OUT);
            return;
        end
        errs = 0;
        for (int j = 0; j < SYM_OUT; j++) begin
            n = (j < 32) ? 992 + j : j - 32;
            if (int'(out_log[base+j].i) != n) errs++;
            if (int'(out_log[base+j].q) != tag - n) errs++;
            if (j > 0 && (out_log[base+j].sop || out_log[base+j].sof)) errs++;
            if (int'(out_log[base+j].cf) != exp_cf) errs++;
            if (out_log[base+j].cyc != out_log[base].cyc + j) errs++;
        end
        checkOutput({name, " osop"}, out_log[base].sop, 1);
        checkOutput({name, " osof"}, out_log[base].sof, exp_sof);
        checkOutput({name, " count_frame"}, out_log[base].cf, exp_cf);
        checkOutput({name, " data errors"}, errs, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        zero_viol      = 0;
        ovf_cnt        = 0;
        err_cnt        = 0;
        last_edge      = 0;
        ordy_after_sop = 1'b0;
        bus.isop       = 1'b0;
        bus.ival       = 1'b0;
        bus.idata_i    = '0;
        bus.idata_q    = '0;
        rst            = 1'b0;

        #2;
        checkOutput("reset oval", bus.oval, 0);
        checkOutput("reset osop", bus.osop, 0);
        checkOutput("reset osof", bus.osof, 0);
        checkOutput("reset ordy", bus.ordy, 0);
        checkOutput("reset oovf", bus.oovf, 0);
        checkOutput("reset odata_i", bus.odata_i, 0);
        checkOutput("reset count_frame", bus.count_frame, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("ordy before first edge", bus.ordy, 0);
        @(posedge clk);
        #1;
        checkOutput("ordy after first edge", bus.ordy, 1);

        $display("[TB] single symbol");
        applyStimulus(0, 1024, 1'b1);
        wait_entries(SYM_OUT, 3000);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("t1 entries", out_log.size(), SYM_OUT);
        if (out_log.size() >= SYM_OUT) begin
            checkOutput("t1 latency", out_log[0].cyc, last_edge + 2);
            checkOutput("t1 first i", out_log[0].i, 992);
            checkOutput("t1 first q", out_log[0].q, -992);
            checkOutput("t1 body start i", out_log[32].i, 0);
            checkOutput("t1 last i", out_log[SYM_OUT-1].i, 1023);
        end
        check_symbol(0, 0, 0, 1'b1, "t1");

        $display("[TB] three symbols");
        do_reset();
        for (int k = 0; k < 3; k++) applyStimulus(k + 1, 1024, 1'b1);
        wait_entries(3 * SYM_OUT, 6000);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("t2 entries", out_log.size(), 3 * SYM_OUT);
        for (int k = 0; k < 3; k++) check_symbol(k * SYM_OUT, k + 1, k, k == 0, $sformatf("t2 sym%0d", k));
        if (out_log.size() >= 3 * SYM_OUT)
            checkOutput("t2 contiguous", out_log[3*SYM_OUT-1].cyc - out_log[0].cyc, 3 * SYM_OUT - 1);

        $display("[TB] overflow");
        do_reset();
        applyStimulus(4, 1024, 1'b1);
        applyStimulus(5, 1024, 1'b0);
        applyStimulus(6, 1024, 1'b0);
        checkOutput("t3 ordy at dropped sop", ordy_after_sop, 0);
        wait_entries(2 * SYM_OUT, 4000);
        repeat (1200) @(posedge clk);
        #1;
        checkOutput("t3 entries", out_log.size(), 2 * SYM_OUT);
        checkOutput("t3 oovf pulses", ovf_cnt, 1);
        checkOutput("t3 oerr pulses", err_cnt, 0);
        check_symbol(0, 4, 0, 1'b1, "t3 sym0");
        check_symbol(SYM_OUT, 5, 1, 1'b0, "t3 sym1");

        $display("[TB] mid-symbol restart");
        do_reset();
        applyStimulus(7, 500, 1'b1);
        applyStimulus(8, 1024, 1'b0);
        wait_entries(SYM_OUT, 3000);
        repeat (1200) @(posedge clk);
        #1;
        checkOutput("t4 entries", out_log.size(), SYM_OUT);
        checkOutput("t4 oerr pulses", err_cnt, 1);
        checkOutput("t4 oovf pulses", ovf_cnt, 0);
        check_symbol(0, 8, 0, 1'b1, "t4");

        $display("[TB] frame wrap");
        do_reset();
        for (int k = 0; k < 51; k++) applyStimulus(k, 1024, 1'b1);
        wait_entries(51 * SYM_OUT, 5000);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("t5 entries", out_log.size(), 51 * SYM_OUT);
        for (int k = 0; k < 51; k++)
            check_symbol(k * SYM_OUT, k, k % 50, (k % 50) == 0, $sformatf("t5 sym%0d", k));

        $display("[TB] reset mid-body");
        do_reset();
        applyStimulus(9, 1024, 1'b1);
        wait_entries(100, 500);
        rst = 1'b0;
        #1;
        checkOutput("t6 oval in reset", bus.oval, 0);
        checkOutput("t6 osop in reset", bus.osop, 0);
        checkOutput("t6 ordy in reset", bus.ordy, 0);
        checkOutput("t6 odata_i in reset", bus.odata_i, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_log.delete();
        ovf_cnt = 0;
        err_cnt = 0;
        @(posedge clk);
        #1;
        applyStimulus(10, 1024, 1'b1);
        wait_entries(SYM_OUT, 3000);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("t6 entries", out_log.size(), SYM_OUT);
        check_symbol(0, 10, 0, 1'b1, "t6");

        checkOutput("idle outputs nonzero", zero_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
